// File: rtl/perf_mon_pkg.sv
// Shared types and constants for the checkpoint-word performance monitor.
package perf_mon_pkg;

  // Measurement state; also driven out of the top as a debug observation point.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  // Default firmware checkpoint codes.
  localparam logic [15:0] DEF_START_CODE = 16'hA000;
  localparam logic [15:0] DEF_STOP_CODE  = 16'hAB00;

  // Width of the sub-kilocycle remainder (holds 0..prescale-1), never below 1.
  function automatic int frac_width(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/perf_code_filter.sv
// Synchronizes the asynchronous checkpoint word and qualifies code changes.
// Interface: accept is a one-cycle strobe and code is meaningful only while
// accept is high; there is no back-pressure, the consumer must take it then.
// Pin-to-accept latency is 2 + STABLE_CYCLES clocks for every code.
module perf_code_filter #(
  parameter int WIDTH         = 16,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [WIDTH-1:0] checkbits,
  input  logic             rearm,
  output logic [WIDTH-1:0] code,
  output logic             accept
);

  localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] hist;
  logic [WIDTH-1:0] last_code;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             stable;

  // Count consecutive identical synchronized samples, saturating at the threshold.
  always_comb begin
    cnt_next = CNT_W'(1);
    if (sync2 == hist) begin
      cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    end
    stable = (cnt_next == CNT_MAX);
  end

  // Synchronizer, sample history and change detection against the last accepted code.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync1     <= '0;
      sync2     <= '0;
      hist      <= '0;
      cnt       <= '0;
      last_code <= '0;
      accept    <= 1'b0;
    end else begin
      sync1  <= checkbits;
      sync2  <= sync1;
      hist   <= sync2;
      cnt    <= cnt_next;
      accept <= 1'b0;
      if (rearm) begin
        // Forgetting the last code lets a code held across a clear re-qualify.
        last_code <= '0;
      end else if (stable && (sync2 != last_code)) begin
        last_code <= sync2;
        accept    <= 1'b1;
      end
    end
  end

  assign code = last_code;

endmodule

// File: rtl/perf_marker_monitor.sv
// Measures cycles between firmware START and STOP checkpoint codes, reporting
// kilocycles plus remainder, with a global timeout counted from enable.
module perf_marker_monitor
  import perf_mon_pkg::*;
#(
  parameter int              WIDTH         = 16,
  parameter logic [WIDTH-1:0] START_CODE   = WIDTH'(DEF_START_CODE),
  parameter logic [WIDTH-1:0] STOP_CODE    = WIDTH'(DEF_STOP_CODE),
  parameter int              PRESCALE      = 1000,
  parameter int              STABLE_CYCLES = 2,
  parameter int              TIMEOUT_K     = 150,
  parameter int              KCNT_W        = 32
) (
  input  logic                                clock,
  input  logic                                resetb,
  input  logic [WIDTH-1:0]                    checkbits,
  input  logic                                enable,
  input  logic                                clear,
  output logic                                running,
  output logic                                done,
  output logic                                passed,
  output logic                                timeout,
  output logic [KCNT_W-1:0]                   kcycles,
  output logic [frac_width(PRESCALE)-1:0]     frac,
  output state_t                              state_dbg
);

  localparam int                FRAC_W   = frac_width(PRESCALE);
  localparam logic [FRAC_W-1:0] FRAC_MAX = FRAC_W'(PRESCALE - 1);
  localparam logic [KCNT_W-1:0] TO_K     = KCNT_W'(TIMEOUT_K);
  localparam logic [KCNT_W-1:0] TO_LAST  = KCNT_W'(TIMEOUT_K - 1);

  state_t            state;
  logic [WIDTH-1:0]  acc_code;
  logic              accept;
  logic              rearm;
  logic              is_start;
  logic              is_stop;
  logic [FRAC_W-1:0] gfrac;
  logic [KCNT_W-1:0] gk;
  logic              g_hit;
  logic [FRAC_W-1:0] frac_inc;
  logic [KCNT_W-1:0] k_inc;

  assign rearm     = clear || !enable;
  assign is_start  = accept && (acc_code == START_CODE);
  assign is_stop   = accept && (acc_code == STOP_CODE);
  assign state_dbg = state;

  perf_code_filter #(
    .WIDTH        (WIDTH),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clock    (clock),
    .resetb   (resetb),
    .checkbits(checkbits),
    .rearm    (rearm),
    .code     (acc_code),
    .accept   (accept)
  );

  // Next measurement value and global timeout detection.
  always_comb begin
    frac_inc = frac + 1'b1;
    k_inc    = kcycles;
    if (frac == FRAC_MAX) begin
      frac_inc = '0;
      k_inc    = (&kcycles) ? kcycles : kcycles + 1'b1;
    end
    // Once the budget is used up it stays used up until clear/enable low.
    g_hit = (gk >= TO_K) || ((gfrac == FRAC_MAX) && (gk == TO_LAST));
  end

  // Global counter: ticks while armed in IDLE or RUN, stops at the timeout budget.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      gfrac <= '0;
      gk    <= '0;
    end else if (rearm) begin
      gfrac <= '0;
      gk    <= '0;
    end else if (((state == IDLE) || (state == RUN)) && (gk < TO_K)) begin
      if (gfrac == FRAC_MAX) begin
        gfrac <= '0;
        gk    <= gk + 1'b1;
      end else begin
        gfrac <= gfrac + 1'b1;
      end
    end
  end

  // Measurement FSM with registered status outputs; STOP outranks timeout, which outranks START.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state   <= IDLE;
      running <= 1'b0;
      done    <= 1'b0;
      passed  <= 1'b0;
      timeout <= 1'b0;
      kcycles <= '0;
      frac    <= '0;
    end else begin
      done <= 1'b0;
      if (rearm) begin
        state   <= IDLE;
        running <= 1'b0;
        passed  <= 1'b0;
        timeout <= 1'b0;
        kcycles <= '0;
        frac    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (g_hit) begin
              state   <= TIMEOUT;
              timeout <= 1'b1;
            end else if (is_start) begin
              state   <= RUN;
              running <= 1'b1;
              kcycles <= '0;
              frac    <= '0;
            end
          end
          RUN: begin
            if (is_stop) begin
              // The stop edge itself is counted so start-to-stop spacing is exact.
              state   <= DONE;
              running <= 1'b0;
              passed  <= 1'b1;
              done    <= 1'b1;
              kcycles <= k_inc;
              frac    <= frac_inc;
            end else if (g_hit) begin
              state   <= TIMEOUT;
              running <= 1'b0;
              timeout <= 1'b1;
            end else if (is_start) begin
              kcycles <= '0;
              frac    <= '0;
            end else begin
              kcycles <= k_inc;
              frac    <= frac_inc;
            end
          end
          DONE: begin
            if (is_start) begin
              state   <= RUN;
              running <= 1'b1;
              passed  <= 1'b0;
              kcycles <= '0;
              frac    <= '0;
            end
          end
          default: begin
            // TIMEOUT: everything frozen until clear or enable low.
            state <= TIMEOUT;
          end
        endcase
      end
    end
  end

endmodule
